axi_rd_arbiter: RTL and testbench
=================================

Name: axi_rd_arbiter

Overview:
Two-master to one-slave AXI4-Lite read-channel arbiter. It lets instruction fetch (master 0) and the data load path (master 1) share one external memory read port. It allows one outstanding transaction at a time and grants by round-robin or fixed priority. It also discards a master-0 response orphaned by a pipeline flush, so fetch never sees stale data after a redirect.

Parameters:
ADDR_WIDTH, 32, AR address width
DATA_WIDTH, 32, R data width
PROT_WIDTH, 3, ARPROT width
RESP_WIDTH, 4, RRESP width (matches existing fetch interface)
FIXED_PRIO, 0, 0 = round-robin; 1 = master 0 always wins ties

Ports:
CLK  input  1  clock; all logic on the rising edge
RST  input  1  synchronous active-high reset
s0_arvalid / s1_arvalid  input  1  master read-address request
s0_arready / s1_arready  output  1  address accepted
s0_araddr / s1_araddr  input  ADDR_WIDTH  read address
s0_arprot / s1_arprot  input  PROT_WIDTH  protection bits
s0_rvalid / s1_rvalid  output  1  response valid to master
s0_rready / s1_rready  input  1  master ready for response
s0_rdata / s1_rdata  output  DATA_WIDTH  response data
s0_rresp / s1_rresp  output  RESP_WIDTH  response code
s0_flush  input  1  fetch redirect; pending master-0 response must be dropped
m_arvalid  output  1  downstream AR valid
m_arready  input  1  downstream AR ready
m_araddr  output  ADDR_WIDTH  downstream address
m_arprot  output  PROT_WIDTH  downstream prot
m_rvalid  input  1  downstream R valid
m_rready  output  1  downstream R ready
m_rdata  input  DATA_WIDTH  downstream data
m_rresp  input  RESP_WIDTH  downstream resp
arb_busy  output  1  high in any state other than IDLE

Behaviour:
- Clocking and reset: one clock CLK; reset RST is synchronous, active-high.
- On reset: state = IDLE, grant = 0, last_grant = 1 (master 0 wins the first tie), drop = 0.
- On reset: all valid/ready outputs and arb_busy are 0.
- Reset mid-transaction aborts to IDLE with no handshake; the downstream slave is reset by the same RST.
- FSM states: IDLE, ADDR, DATA.
- IDLE: if any sX_arvalid is high, register grant and go to ADDR.
  - Both requesting, FIXED_PRIO=0: grant = ~last_grant.
  - Both requesting, FIXED_PRIO=1: grant = 0.
  - No sX_arready in IDLE. Minimum latency: request in cycle N, m_arvalid in cycle N+1.
- ADDR:
  - m_arvalid = 1; m_araddr/m_arprot are muxed combinationally from the granted master.
  - s{grant}_arready = m_arready; the other master's arready = 0.
  - On m_arvalid & m_arready, go to DATA.
  - The granted master must hold its AR stable (AXI rule); m_arvalid is never retracted, even on flush.
- DATA:
  - Granted master: sX_rvalid = m_rvalid & ~drop_now; rdata/rresp pass through.
  - m_rready = drop_now ? 1 : s{grant}_rready.
  - drop_now = drop | (s0_flush & grant==0).
  - On m_rvalid & m_rready: go to IDLE, last_grant <= grant, drop <= 0.
- Non-granted master: rvalid = 0, arready = 0 at all times.
- Drop rule:
  - s0_flush while grant==0 in ADDR or DATA sets drop (sticky until the R handshake).
  - Flush in the same cycle as the R handshake suppresses s0_rvalid in that cycle; the beat is consumed internally.
  - s0_flush has no effect in IDLE or when grant==1.
- A requester deasserting arvalid while in IDLE before grant is legal; the grant samples only the current cycle.
- Back-to-back: after the R handshake, IDLE costs one cycle, so throughput is at most one transaction per 3 cycles.
- arb_busy = (state != IDLE).

Decomposition:
- Shared package: FSM encodings ST_IDLE=2'd0, ST_ADDR=2'd1, ST_DATA=2'd2; grant index constants GNT_IF=1'b0, GNT_LSU=1'b1.
- One sub-module: rr_pick2 (combinational 2-way round-robin/fixed picker: inputs req[1:0], last, fixed; output gnt).
- Everything else stays in axi_rd_arbiter.

Test Plan:
- Single fetch: s0 AR 0x0000_1000 in cycle 0, m_arready=1 -> m_arvalid in cycle 1 with that address; m_rdata=0x0000_0013 returned -> s0_rvalid with that data; s1_rvalid stays 0.
- Contention, FIXED_PRIO=0: both request repeatedly -> grants alternate 0,1,0,1 across four transactions; first grant is 0 after reset.
- Contention, FIXED_PRIO=1: both request continuously -> s0 served every transaction; s1 served only once s0_arvalid drops.
- Flush in DATA: s0 grant, s0_flush pulse before m_rvalid, m_rvalid arrives 3 cycles later -> m_rready=1, s0_rvalid=0, FSM returns to IDLE.
- Flush on s1 transaction: s0_flush pulse while grant=1 -> s1 receives 0xDEAD_BEEF normally.
- Back-pressure and reset: m_arready held 0 for 5 cycles -> m_arvalid/m_araddr stable throughout; RST asserted in DATA -> next cycle all outputs 0, arb_busy=0.

Source files
------------

// File: rtl/axi_rd_arbiter_pkg.sv
// Shared encodings for the two-master AXI4-Lite read arbiter.
package axi_rd_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } arb_state_t;

    localparam logic GNT_IF  = 1'b0;
    localparam logic GNT_LSU = 1'b1;

endpackage

// File: rtl/axi_rd_arbiter_rr_pick2.sv
// Two-way request picker: round-robin on ties, or master 0 wins ties when fixed.
module rr_pick2
    import axi_rd_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    input  logic       fixed,
    output logic       gnt
);

    always_comb begin
        gnt = GNT_IF;
        if (req == 2'b11) begin
            gnt = fixed ? GNT_IF : ~last;
        end else if (req[1]) begin
            gnt = GNT_LSU;
        end
    end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Two-master to one-slave AXI4-Lite read arbiter, one outstanding transaction,
// with discard of a fetch response orphaned by a pipeline flush.
module axi_rd_arbiter
    import axi_rd_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned PROT_WIDTH = 3,
    parameter int unsigned RESP_WIDTH = 4,
    parameter int unsigned FIXED_PRIO = 0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  s0_arvalid,
    output logic                  s0_arready,
    input  logic [ADDR_WIDTH-1:0] s0_araddr,
    input  logic [PROT_WIDTH-1:0] s0_arprot,
    output logic                  s0_rvalid,
    input  logic                  s0_rready,
    output logic [DATA_WIDTH-1:0] s0_rdata,
    output logic [RESP_WIDTH-1:0] s0_rresp,
    input  logic                  s0_flush,
    input  logic                  s1_arvalid,
    output logic                  s1_arready,
    input  logic [ADDR_WIDTH-1:0] s1_araddr,
    input  logic [PROT_WIDTH-1:0] s1_arprot,
    output logic                  s1_rvalid,
    input  logic                  s1_rready,
    output logic [DATA_WIDTH-1:0] s1_rdata,
    output logic [RESP_WIDTH-1:0] s1_rresp,
    output logic                  m_arvalid,
    input  logic                  m_arready,
    output logic [ADDR_WIDTH-1:0] m_araddr,
    output logic [PROT_WIDTH-1:0] m_arprot,
    input  logic                  m_rvalid,
    output logic                  m_rready,
    input  logic [DATA_WIDTH-1:0] m_rdata,
    input  logic [RESP_WIDTH-1:0] m_rresp,
    output logic                  arb_busy
);

    localparam logic FIXED = (FIXED_PRIO != 0);

    arb_state_t state;
    logic       grant;
    logic       last_grant;
    logic       drop;
    logic       pick;
    logic       in_addr;
    logic       in_data;
    logic       flush_hit;
    logic       drop_now;
    logic       gnt_rready;

    rr_pick2 u_pick (
        .req   ({s1_arvalid, s0_arvalid}),
        .last  (last_grant),
        .fixed (FIXED),
        .gnt   (pick)
    );

    assign in_addr    = (state == ST_ADDR);
    assign in_data    = (state == ST_DATA);
    assign flush_hit  = s0_flush & (grant == GNT_IF);
    // A flush landing on the response beat itself must already hide that beat.
    assign drop_now   = drop | flush_hit;
    assign gnt_rready = (grant == GNT_LSU) ? s1_rready : s0_rready;

    always_comb begin
        arb_busy   = (state != ST_IDLE);
        m_arvalid  = in_addr;
        m_araddr   = (grant == GNT_LSU) ? s1_araddr : s0_araddr;
        m_arprot   = (grant == GNT_LSU) ? s1_arprot : s0_arprot;
        s0_arready = in_addr & (grant == GNT_IF) & m_arready;
        s1_arready = in_addr & (grant == GNT_LSU) & m_arready;
        m_rready   = in_data & (drop_now | gnt_rready);
        s0_rvalid  = in_data & (grant == GNT_IF) & m_rvalid & ~drop_now;
        s1_rvalid  = in_data & (grant == GNT_LSU) & m_rvalid;
        s0_rdata   = m_rdata;
        s1_rdata   = m_rdata;
        s0_rresp   = m_rresp;
        s1_rresp   = m_rresp;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= ST_IDLE;
            grant      <= GNT_IF;
            last_grant <= GNT_LSU;
            drop       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (s0_arvalid | s1_arvalid) begin
                        grant <= pick;
                        state <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (flush_hit) drop <= 1'b1;
                    if (m_arready) state <= ST_DATA;
                end
                ST_DATA: begin
                    if (m_rvalid & m_rready) begin
                        state      <= ST_IDLE;
                        last_grant <= grant;
                        drop       <= 1'b0;
                    end else if (flush_hit) begin
                        drop <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Self-checking bench: round-robin and fixed-priority arbiters on shared stimulus,
// each checked every cycle against a transaction-level model.
module tb_axi_rd_arbiter;

    logic        CLK;
    logic        RST;
    logic        s0_arvalid, s1_arvalid;
    logic [31:0] s0_araddr, s1_araddr;
    logic [2:0]  s0_arprot, s1_arprot;
    logic        s0_rready, s1_rready;
    logic        s0_flush;
    logic        m_arready, m_rvalid;
    logic [31:0] m_rdata;
    logic [3:0]  m_rresp;

    logic        o_s0_arready [2];
    logic        o_s1_arready [2];
    logic        o_s0_rvalid  [2];
    logic        o_s1_rvalid  [2];
    logic [31:0] o_s0_rdata   [2];
    logic [31:0] o_s1_rdata   [2];
    logic [3:0]  o_s0_rresp   [2];
    logic [3:0]  o_s1_rresp   [2];
    logic        o_m_arvalid  [2];
    logic [31:0] o_m_araddr   [2];
    logic [2:0]  o_m_arprot   [2];
    logic        o_m_rready   [2];
    logic        o_busy       [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        axi_rd_arbiter #(
            .ADDR_WIDTH (32),
            .DATA_WIDTH (32),
            .PROT_WIDTH (3),
            .RESP_WIDTH (4),
            .FIXED_PRIO (g)
        ) u_dut (
            .CLK        (CLK),
            .RST        (RST),
            .s0_arvalid (s0_arvalid),
            .s0_arready (o_s0_arready[g]),
            .s0_araddr  (s0_araddr),
            .s0_arprot  (s0_arprot),
            .s0_rvalid  (o_s0_rvalid[g]),
            .s0_rready  (s0_rready),
            .s0_rdata   (o_s0_rdata[g]),
            .s0_rresp   (o_s0_rresp[g]),
            .s0_flush   (s0_flush),
            .s1_arvalid (s1_arvalid),
            .s1_arready (o_s1_arready[g]),
            .s1_araddr  (s1_araddr),
            .s1_arprot  (s1_arprot),
            .s1_rvalid  (o_s1_rvalid[g]),
            .s1_rready  (s1_rready),
            .s1_rdata   (o_s1_rdata[g]),
            .s1_rresp   (o_s1_rresp[g]),
            .m_arvalid  (o_m_arvalid[g]),
            .m_arready  (m_arready),
            .m_araddr   (o_m_araddr[g]),
            .m_arprot   (o_m_arprot[g]),
            .m_rvalid   (m_rvalid),
            .m_rready   (o_m_rready[g]),
            .m_rdata    (m_rdata),
            .m_rresp    (m_rresp),
            .arb_busy   (o_busy[g])
        );
    end

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    // Transaction-level view per arbiter (index 0 = round-robin, 1 = fixed priority).
    bit mbusy [2];
    bit mwait_ar [2];
    bit mown [2];
    bit mlast [2];
    bit mdrop [2];
    bit model_ok = 0;
    bit gq [2][$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare(input int p);
        bit arv, dph, disc, own, exp_s0rv, exp_s1rv;
        own  = mown[p];
        arv  = mbusy[p] & mwait_ar[p];
        dph  = mbusy[p] & ~mwait_ar[p];
        disc = mdrop[p] | (s0_flush & (own == 1'b0));
        chk($sformatf("busy[%0d]", p), o_busy[p], mbusy[p]);
        chk($sformatf("m_arvalid[%0d]", p), o_m_arvalid[p], arv);
        if (arv) begin
            chk($sformatf("m_araddr[%0d]", p), o_m_araddr[p], own ? s1_araddr : s0_araddr);
            chk($sformatf("m_arprot[%0d]", p), o_m_arprot[p], own ? s1_arprot : s0_arprot);
        end
        chk($sformatf("s0_arready[%0d]", p), o_s0_arready[p], arv & ~own & m_arready);
        chk($sformatf("s1_arready[%0d]", p), o_s1_arready[p], arv & own & m_arready);
        chk($sformatf("m_rready[%0d]", p), o_m_rready[p],
            dph & (disc | (own ? s1_rready : s0_rready)));
        exp_s0rv = dph & ~own & m_rvalid & ~disc;
        exp_s1rv = dph & own & m_rvalid;
        chk($sformatf("s0_rvalid[%0d]", p), o_s0_rvalid[p], exp_s0rv);
        chk($sformatf("s1_rvalid[%0d]", p), o_s1_rvalid[p], exp_s1rv);
        if (exp_s0rv) begin
            chk($sformatf("s0_rdata[%0d]", p), o_s0_rdata[p], m_rdata);
            chk($sformatf("s0_rresp[%0d]", p), o_s0_rresp[p], m_rresp);
        end
        if (exp_s1rv) begin
            chk($sformatf("s1_rdata[%0d]", p), o_s1_rdata[p], m_rdata);
            chk($sformatf("s1_rresp[%0d]", p), o_s1_rresp[p], m_rresp);
        end
    endtask

    task automatic advance(input int p);
        bit own, disc, hs;
        own  = mown[p];
        disc = mdrop[p] | (s0_flush & (own == 1'b0));
        if (RST) begin
            mbusy[p] = 0; mwait_ar[p] = 0; mown[p] = 0; mlast[p] = 1; mdrop[p] = 0;
        end else if (!mbusy[p]) begin
            if (s0_arvalid | s1_arvalid) begin
                if (s0_arvalid & s1_arvalid) mown[p] = (p == 1) ? 1'b0 : ~mlast[p];
                else                         mown[p] = s1_arvalid;
                mbusy[p] = 1; mwait_ar[p] = 1;
            end
        end else if (mwait_ar[p]) begin
            if (s0_flush & ~own) mdrop[p] = 1;
            if (m_arready) mwait_ar[p] = 0;
        end else begin
            hs = m_rvalid & (disc | (own ? s1_rready : s0_rready));
            if (hs) begin
                mbusy[p] = 0; mlast[p] = own; mdrop[p] = 0;
            end else if (s0_flush & ~own) begin
                mdrop[p] = 1;
            end
        end
    endtask

    // One clock: compare before the edge, advance the model at the edge, return at negedge.
    task automatic step();
        #1;
        for (int p = 0; p < 2; p++) begin
            if (model_ok) compare(p);
            if (o_s0_arready[p] | o_s1_arready[p]) gq[p].push_back(o_s1_arready[p]);
        end
        @(posedge CLK);
        for (int p = 0; p < 2; p++) advance(p);
        if (RST) model_ok = 1;
        @(negedge CLK);
    endtask

    task automatic idle_inputs();
        s0_arvalid = 0; s1_arvalid = 0; s0_flush = 0;
        s0_rready = 0; s1_rready = 0;
        m_arready = 0; m_rvalid = 0; m_rdata = '0; m_rresp = '0;
    endtask

    task automatic do_reset();
        RST = 1;
        step();
        RST = 0;
    endtask

    initial begin
        bit lock0, lock1;
        RST = 1;
        s0_araddr = '0; s1_araddr = '0; s0_arprot = '0; s1_arprot = '0;
        idle_inputs();
        @(negedge CLK);
        do_reset();

        #1;
        chk("rst_busy", o_busy[0], 0);
        chk("rst_arvalid", o_m_arvalid[0], 0);
        chk("rst_rready", o_m_rready[0], 0);

        // Single fetch
        s0_arvalid = 1; s0_araddr = 32'h0000_1000; s0_arprot = 3'd2; m_arready = 1;
        #1;
        chk("fetch_no_arvalid_n", o_m_arvalid[0], 0);
        chk("fetch_no_arready_n", o_s0_arready[0], 0);
        step();
        chk("fetch_arvalid_n1", o_m_arvalid[0], 1);
        chk("fetch_araddr", o_m_araddr[0], 32'h0000_1000);
        step();
        s0_arvalid = 0; m_rvalid = 1; m_rdata = 32'h0000_0013; s0_rready = 1;
        #1;
        chk("fetch_rvalid", o_s0_rvalid[0], 1);
        chk("fetch_rdata", o_s0_rdata[0], 32'h0000_0013);
        chk("fetch_s1_quiet", o_s1_rvalid[0], 0);
        step();
        idle_inputs();
        #1;
        chk("fetch_done_idle", o_busy[0], 0);

        // Contention: both masters request continuously
        do_reset();
        s0_arvalid = 1; s1_arvalid = 1; s0_araddr = 32'h100; s1_araddr = 32'h200;
        m_arready = 1; m_rvalid = 1; s0_rready = 1; s1_rready = 1;
        gq[0].delete(); gq[1].delete();
        repeat (12) step();
        chk("rr_count", gq[0].size(), 4);
        chk("fp_count", gq[1].size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rr_grant%0d", i), gq[0][i], i % 2);
            chk($sformatf("fp_grant%0d", i), gq[1][i], 0);
        end
        s0_arvalid = 0;
        gq[1].delete();
        repeat (3) step();
        chk("fp_s1_served", gq[1].size() > 0 ? gq[1][0] : 1'b0, 1);
        idle_inputs();

        // Flush while waiting for the fetch response
        do_reset();
        s0_arvalid = 1; s0_araddr = 32'h40; m_arready = 1;
        step();
        step();
        s0_arvalid = 0; s0_flush = 1;
        step();
        s0_flush = 0;
        step();
        step();
        m_rvalid = 1; m_rdata = 32'h1234_5678; s0_rready = 0;
        #1;
        chk("flush_m_rready", o_m_rready[0], 1);
        chk("flush_s0_rvalid", o_s0_rvalid[0], 0);
        step();
        idle_inputs();
        #1;
        chk("flush_back_idle", o_busy[0], 0);

        // Flush during a load transaction has no effect
        s1_arvalid = 1; s1_araddr = 32'h80; m_arready = 1;
        step();
        s0_flush = 1;
        step();
        s1_arvalid = 0; m_rvalid = 1; m_rdata = 32'hDEAD_BEEF; s1_rready = 1;
        #1;
        chk("s1_flush_rvalid", o_s1_rvalid[0], 1);
        chk("s1_flush_rdata", o_s1_rdata[0], 32'hDEAD_BEEF);
        step();
        idle_inputs();

        // Address back-pressure, then reset while in the data phase
        s0_arvalid = 1; s0_araddr = 32'h3000; m_arready = 0;
        step();
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("bp_arvalid%0d", i), o_m_arvalid[0], 1);
            chk($sformatf("bp_araddr%0d", i), o_m_araddr[0], 32'h3000);
            step();
        end
        m_arready = 1;
        step();
        s0_arvalid = 0; m_arready = 0; RST = 1;
        step();
        RST = 0; m_rvalid = 1; s0_rready = 1; s1_rready = 1; m_arready = 1;
        #1;
        chk("rst_data_busy", o_busy[0], 0);
        chk("rst_data_arvalid", o_m_arvalid[0], 0);
        chk("rst_data_rready", o_m_rready[0], 0);
        chk("rst_data_rvalid", o_s0_rvalid[0], 0);
        chk("rst_data_arready", o_s0_arready[0], 0);
        step();
        idle_inputs();

        // Randomized traffic; a master holds its AR while any arbiter is waiting on it
        for (int c = 0; c < 3000; c++) begin
            lock0 = 0; lock1 = 0;
            for (int p = 0; p < 2; p++) begin
                if (mbusy[p] & mwait_ar[p] & ~mown[p]) lock0 = 1;
                if (mbusy[p] & mwait_ar[p] & mown[p])  lock1 = 1;
            end
            if (!lock0) begin
                s0_arvalid = ($urandom_range(0, 2) != 0);
                s0_araddr  = $urandom;
                s0_arprot  = 3'($urandom);
            end
            if (!lock1) begin
                s1_arvalid = ($urandom_range(0, 2) != 0);
                s1_araddr  = $urandom;
                s1_arprot  = 3'($urandom);
            end
            s0_rready = $urandom_range(0, 1);
            s1_rready = $urandom_range(0, 1);
            s0_flush  = ($urandom_range(0, 7) == 0);
            m_arready = $urandom_range(0, 1);
            m_rvalid  = $urandom_range(0, 1);
            m_rdata   = $urandom;
            m_rresp   = 4'($urandom);
            RST       = ($urandom_range(0, 199) == 0);
            step();
        end
        RST = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
